// File: rtl/saikoro_pkg.sv
// Shared definitions for the saikoro dice family: roll-controller state
// encoding and default parameter values used by the RTL and the benches.
package saikoro_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SPIN = 2'd1,
      SLOW = 2'd2,
      DONE = 2'd3
   } roll_state_t;

   localparam int DEF_DEB_CYCLES = 4;
   localparam int DEF_DEB_W      = 8;
   localparam int DEF_GAP_INIT   = 1;
   localparam int DEF_GAP_MAX    = 8;
   localparam int DEF_GAP_W      = 8;

endpackage

// File: rtl/saikoro_debounce.sv
// Two-flop synchroniser followed by a counting debouncer: the output level
// flips only after DEB_CYCLES consecutive cycles of disagreement.
module saikoro_debounce
   import saikoro_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int DEB_W      = DEF_DEB_W
) (
   input  logic ck,
   input  logic reset_n,
   input  logic din,
   output logic dout
);

   logic [1:0]       sync_reg;
   logic [DEB_W-1:0] cnt_reg;
   logic             deb_reg;

   always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
         sync_reg <= '0;
         cnt_reg  <= '0;
         deb_reg  <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], din};
         // any agreeing cycle restarts the stability count
         if (sync_reg[1] == deb_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
            deb_reg <= ~deb_reg;
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign dout = deb_reg;

endmodule

// File: rtl/saikoro_roll_ctrl.sv
// Roll controller for the saikoro dice: enable follows the debounced button,
// then a doubling-gap pulse train slows the dice before flagging done.
module saikoro_roll_ctrl
   import saikoro_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int DEB_W      = DEF_DEB_W,
   parameter int GAP_INIT   = DEF_GAP_INIT,
   parameter int GAP_MAX    = DEF_GAP_MAX,
   parameter int GAP_W      = DEF_GAP_W
) (
   input  logic ck,
   input  logic reset_n,
   input  logic btn,
   output logic enable,
   output logic rolling,
   output logic done
);

   localparam logic [GAP_W:0] GAP_MAX_X = (GAP_W + 1)'(GAP_MAX);

   roll_state_t      state_reg, state_next;
   logic [GAP_W-1:0] g_reg, g_next;
   logic [GAP_W-1:0] c_reg, c_next;
   logic [GAP_W:0]   g_dbl;
   logic             deb, deb_q_reg, deb_rise, deb_fall;
   logic             enable_reg, enable_next;
   logic             rolling_reg, rolling_next;
   logic             done_reg, done_next;

   saikoro_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W)
   ) u_debounce (
      .ck      (ck),
      .reset_n (reset_n),
      .din     (btn),
      .dout    (deb)
   );

   assign deb_rise = deb & ~deb_q_reg;
   assign deb_fall = ~deb & deb_q_reg;
   assign g_dbl    = {g_reg, 1'b0};

   always_comb begin
      state_next  = state_reg;
      g_next      = g_reg;
      c_next      = c_reg;
      enable_next = 1'b0;
      case (state_reg)
         IDLE: if (deb_rise) state_next = SPIN;
         SPIN: begin
            if (deb_fall) begin
               state_next = SLOW;
               g_next     = GAP_W'(GAP_INIT);
               c_next     = '0;
            end
         end
         SLOW: begin
            // enable_reg high here means a pulse is on the wire this cycle
            if (deb_rise) begin
               state_next = SPIN;
            end else if (enable_reg) begin
               if (g_dbl > GAP_MAX_X) begin
                  state_next = DONE;
               end else begin
                  g_next = g_dbl[GAP_W-1:0];
                  c_next = '0;
               end
            end else if (c_reg == g_reg - 1'b1) begin
               enable_next = 1'b1;
            end else begin
               c_next = c_reg + 1'b1;
            end
         end
         DONE:    state_next = deb_rise ? SPIN : IDLE;
         default: state_next = IDLE;
      endcase
      if (state_next == SPIN) enable_next = 1'b1;
      rolling_next = (state_next == SPIN) || (state_next == SLOW);
      done_next    = (state_next == DONE);
   end

   always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         g_reg       <= '0;
         c_reg       <= '0;
         deb_q_reg   <= 1'b0;
         enable_reg  <= 1'b0;
         rolling_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         g_reg       <= g_next;
         c_reg       <= c_next;
         deb_q_reg   <= deb;
         enable_reg  <= enable_next;
         rolling_reg <= rolling_next;
         done_reg    <= done_next;
      end
   end

   assign enable  = enable_reg;
   assign rolling = rolling_reg;
   assign done    = done_reg;

endmodule

// File: tb/tb_saikoro_roll_ctrl.sv
// Scoreboard bench for saikoro_roll_ctrl: stimulus queues expected output
// edges with their cycle numbers, a negedge monitor pops and compares them.
module tb_saikoro_roll_ctrl;

   localparam int EV_EN_RISE   = 0;
   localparam int EV_EN_FALL   = 1;
   localparam int EV_DONE      = 2;
   localparam int EV_ROLL_RISE = 3;
   localparam int EV_ROLL_FALL = 4;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic ck      = 1'b0;
   logic reset_n = 1'b1;
   logic btn_a   = 1'b0;
   logic btn_b   = 1'b0;
   logic enable_a, rolling_a, done_a;
   logic enable_b, rolling_b, done_b;

   int   cyc         = 0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   req_seq     = 0;
   int   ack_seq     = 0;
   int   exp_en_hi   = 0;
   int   en_hi_a     = 0;
   bit   finish_req  = 1'b0;
   ev_t  q_a[$];
   ev_t  q_b[$];

   saikoro_roll_ctrl u_dut_a (
      .ck      (ck),
      .reset_n (reset_n),
      .btn     (btn_a),
      .enable  (enable_a),
      .rolling (rolling_a),
      .done    (done_a)
   );

   saikoro_roll_ctrl #(
      .GAP_INIT (2),
      .GAP_MAX  (16)
   ) u_dut_b (
      .ck      (ck),
      .reset_n (reset_n),
      .btn     (btn_b),
      .enable  (enable_b),
      .rolling (rolling_b),
      .done    (done_b)
   );

   always #5 ck = ~ck;

   always @(posedge ck) cyc <= cyc + 1;

   task automatic push(input int inst, input int kind, input int c);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      if (inst == 0) q_a.push_back(e);
      else           q_b.push_back(e);
   endtask

   // enable and rolling rise DEB_CYCLES+3 = 7 edges after the press
   task automatic push_press(input int inst, input int p);
      push(inst, EV_EN_RISE, p + 7);
      push(inst, EV_ROLL_RISE, p + 7);
   endtask

   // hand-computed pulse edges after release r; A gaps 1,2,4,8, B gaps 2,4,8,16
   task automatic push_release(input int inst, input int r, input int npulse, input bit fin);
      int rise_a[4] = '{8, 11, 16, 25};
      int fall_a[4] = '{9, 12, 17, 26};
      int rise_b[4] = '{9, 14, 23, 40};
      int fall_b[4] = '{10, 15, 24, 41};
      push(inst, EV_EN_FALL, r + 7);
      for (int k = 0; k < npulse; k++) begin
         push(inst, EV_EN_RISE, r + ((inst == 0) ? rise_a[k] : rise_b[k]));
         push(inst, EV_EN_FALL, r + ((inst == 0) ? fall_a[k] : fall_b[k]));
      end
      if (fin) begin
         push(inst, EV_DONE, r + ((inst == 0) ? 26 : 41));
         push(inst, EV_ROLL_FALL, r + ((inst == 0) ? 26 : 41));
      end
   endtask

   task automatic check_ev(input int inst, input int kind);
      ev_t e;
      bit  have;
      have = 1'b0;
      if (inst == 0) begin
         if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      end else begin
         if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      end
      vectors++;
      if (!have) begin
         miscompares++;
         $display("FAIL unexpected_event dut%0d: got kind %0d at cycle %0d, required no event",
                  inst, kind, cyc);
      end else if (e.kind != kind || e.cyc != cyc) begin
         miscompares++;
         $display("FAIL event dut%0d: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                  inst, kind, cyc, e.kind, e.cyc);
      end
   endtask

   task automatic request_check(input int add_hi);
      exp_en_hi += add_hi;
      req_seq++;
      repeat (2) @(negedge ck);
   endtask

   // monitor: the only process that counts comparisons
   initial begin
      logic [1:0] en, ro, dn;
      logic [1:0] prev_en, prev_ro;
      prev_en = '0;
      prev_ro = '0;
      forever begin
         @(negedge ck);
         en = {enable_b, enable_a};
         ro = {rolling_b, rolling_a};
         dn = {done_b, done_a};
         if (!reset_n) begin
            vectors++;
            if (en != 2'b00 || ro != 2'b00 || dn != 2'b00) begin
               miscompares++;
               $display("FAIL reset_outputs: enable=%b rolling=%b done=%b, required all 00",
                        en, ro, dn);
            end
            en_hi_a = 0;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (en[i] && !prev_en[i]) check_ev(i, EV_EN_RISE);
               if (!en[i] && prev_en[i]) check_ev(i, EV_EN_FALL);
               if (dn[i])                check_ev(i, EV_DONE);
               if (ro[i] && !prev_ro[i]) check_ev(i, EV_ROLL_RISE);
               if (!ro[i] && prev_ro[i]) check_ev(i, EV_ROLL_FALL);
            end
            if (enable_a) en_hi_a++;
         end
         prev_en = en;
         prev_ro = ro;
         if (ack_seq != req_seq) begin
            ack_seq = req_seq;
            vectors++;
            if (q_a.size() != 0) begin
               miscompares++;
               $display("FAIL pending_a: got %0d events never seen, required 0", q_a.size());
               q_a.delete();
            end
            vectors++;
            if (q_b.size() != 0) begin
               miscompares++;
               $display("FAIL pending_b: got %0d events never seen, required 0", q_b.size());
               q_b.delete();
            end
            vectors++;
            if (en_hi_a != exp_en_hi) begin
               miscompares++;
               $display("FAIL enable_high_count: got %0d cycles, required %0d",
                        en_hi_a, exp_en_hi);
            end
         end
         if (finish_req) begin
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
         end
      end
   end

   // stimulus
   initial begin
      int p, r, r2;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge ck);
      reset_n = 1'b1;
      repeat (5) @(negedge ck);

      // glitch: 3 cycles high is one short of the debounce threshold
      btn_a = 1'b1;
      repeat (3) @(negedge ck);
      btn_a = 1'b0;
      repeat (20) @(negedge ck);
      request_check(0);

      // full roll on both instances, 20-cycle hold
      p = cyc;
      push_press(0, p);
      push_press(1, p);
      btn_a = 1'b1;
      btn_b = 1'b1;
      repeat (20) @(negedge ck);
      r = cyc;
      push_release(0, r, 4, 1'b1);
      push_release(1, r, 4, 1'b1);
      btn_a = 1'b0;
      btn_b = 1'b0;
      repeat (50) @(negedge ck);
      request_check(24);

      // re-press after the second pulse, during the 4-cycle gap
      p = cyc;
      push_press(0, p);
      btn_a = 1'b1;
      repeat (20) @(negedge ck);
      r = cyc;
      push_release(0, r, 2, 1'b0);
      btn_a = 1'b0;
      repeat (6) @(negedge ck);
      push(0, EV_EN_RISE, r + 13);
      btn_a = 1'b1;
      repeat (12) @(negedge ck);
      r2 = cyc;
      push_release(0, r2, 4, 1'b1);
      btn_a = 1'b0;
      repeat (40) @(negedge ck);
      request_check(38);

      // re-press landing on the same edge as the third pulse
      p = cyc;
      push_press(0, p);
      btn_a = 1'b1;
      repeat (20) @(negedge ck);
      r = cyc;
      push_release(0, r, 2, 1'b0);
      btn_a = 1'b0;
      repeat (9) @(negedge ck);
      push(0, EV_EN_RISE, r + 16);
      btn_a = 1'b1;
      repeat (10) @(negedge ck);
      r2 = cyc;
      push_release(0, r2, 4, 1'b1);
      btn_a = 1'b0;
      repeat (40) @(negedge ck);
      request_check(36);

      // asynchronous reset while spinning
      p = cyc;
      push_press(0, p);
      btn_a = 1'b1;
      repeat (10) @(negedge ck);
      @(posedge ck);
      #2;
      reset_n = 1'b0;
      btn_a   = 1'b0;
      repeat (3) @(negedge ck);
      reset_n = 1'b1;
      repeat (20) @(negedge ck);
      exp_en_hi = 0;
      request_check(0);

      finish_req = 1'b1;
      repeat (10) @(negedge ck);
      $display("FAIL watchdog: summary not reached, required monitor to finish");
      $fatal(1, "bench stalled");
   end

endmodule

// File: doc/saikoro_roll_ctrl.md
# saikoro_roll_ctrl

Roll controller that sits directly upstream of the electronic-dice counter `saikoro` and drives its `enable` input from a raw push button. It synchronises and debounces the button, then holds `enable` high while the button is held. On release it emits a decelerating train of single-cycle `enable` pulses, so the dice visibly slows before stopping, and finally flags the settled result.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive stable cycles required to accept a button level change.
- `DEB_W`, default 8: debounce counter width; must satisfy `DEB_CYCLES < 2**DEB_W`.
- `GAP_INIT`, default 1: idle cycles before the first slow-down pulse; must be at least 1.
- `GAP_MAX`, default 8: largest gap allowed; must satisfy `GAP_INIT <= GAP_MAX`.
- `GAP_W`, default 8: gap register width; must be wide enough to hold `2*GAP_MAX`.

Ports (clock and reset first):
- `ck`, in, 1: single clock; all state changes on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `btn`, in, 1: raw push button, asynchronous to `ck`, active-high.
- `enable`, out, 1: registered; connects to `saikoro` enable.
- `rolling`, out, 1: registered; high in SPIN and SLOW.
- `done`, out, 1: registered; one-cycle pulse when the roll has settled.

## Operation
- Input path: `btn` passes through a 2-FF synchroniser to produce `btn_s`.
- Debounce: the counter increments on every cycle where `btn_s != deb`. It clears whenever `btn_s == deb`. On the DEB_CYCLES-th consecutive mismatch, `deb` toggles and the counter clears.
- States: IDLE, SPIN, SLOW, DONE.
- IDLE: `enable=0`. Moves to SPIN when `deb` rises.
- SPIN: `enable=1` on every cycle. Moves to SLOW when `deb` falls, loading gap `g=GAP_INIT` and idle counter `c=0`.
- SLOW: `enable=0` for `g` cycles, then `enable=1` for exactly one cycle.
  - After each pulse, if `2*g > GAP_MAX` the FSM goes to DONE.
  - Otherwise `g <= 2*g`, `c <= 0`, and SLOW continues.
  - Default parameters give pulses after gaps of 1, 2, 4 and 8 cycles: 4 pulses, then DONE.
- DONE: `done=1` and `enable=0` for one cycle, then IDLE.
- Re-press (rising `deb`) during SLOW or DONE: go to SPIN. Any pending pulse is abandoned, `g` and `c` are discarded, and `done` is not asserted.
- A `deb` rise and a scheduled pulse in the same cycle: the rise wins, so the next state is SPIN and `enable=1` continues from SPIN.
- Arithmetic: `g` doubling is computed at GAP_W+1 bits before the compare, so it cannot wrap.

## Timing
- Reset (asynchronous assert, any state, including mid-roll):
  - `enable=0`, `rolling=0`, `done=0`.
  - State IDLE; synchroniser FFs, `deb`, debounce counter, `g` and `c` all cleared.
  - Deassertion is synchronous to `ck`.
- Latency from a `btn` edge to the `deb` change: DEB_CYCLES+2 rising edges, assuming `btn` is stable.
- `enable` and `rolling` change one edge after `deb` changes, so the total is DEB_CYCLES+3 edges. With defaults, `enable` rises on the 7th edge after `btn` rises.
- `btn` glitches shorter than DEB_CYCLES cycles at `btn_s` produce no `deb` change.
- `rolling` stays high through every SLOW cycle. It drops on the same edge that asserts `done`.
- SLOW duration: the sum of all gaps plus one cycle per pulse. With defaults this is 15 + 4 = 19 cycles.

## Structure
- Shared package `saikoro_pkg` holds:
  - the state encoding constants (IDLE=2'd0, SPIN=2'd1, SLOW=2'd2, DONE=2'd3);
  - the default parameter values, shared with the `saikoro` bench.
- One sub-module, `saikoro_debounce`, contains the synchroniser plus the debounce counter. Its ports are `ck`, `reset_n`, `din` and `dout`.
- The top level holds the FSM, `g`, `c` and the output registers.

## Test plan
- Reset mid-SPIN: assert `reset_n=0` while `enable=1` -> `enable`, `rolling` and `done` go to 0 immediately; the FSM stays in IDLE after release.
- Glitch rejection: `btn` high for 3 cycles, then low -> `enable` stays 0 throughout.
- Full roll (defaults): hold `btn` for 20 cycles, then release ->
  - `enable` rises at edge 7 and stays high while held;
  - after release, exactly 4 `enable` pulses separated by 1, 2, 4 and 8 low cycles;
  - then `done` for one cycle, with `rolling` low from that edge.
- Re-press during SLOW: press again after the 2nd pulse -> `enable` is held high again DEB_CYCLES+3 edges later and no `done` occurs. After release, the pulse train restarts with a gap of 1.
- Chained with `saikoro`: count the `enable` high cycles and compare the dice count modulo 6 -> `sai.cnt` advances exactly once per `enable` high cycle; the `lamp` pattern is stable after `done`.
- Parameter sweep: `GAP_INIT=2`, `GAP_MAX=16` -> gaps of 2, 4, 8 and 16, i.e. 4 pulses, then `done`.
